// File: rtl/genius_sequence_engine.sv
// ---------------------------------------------------------------------------
// genius_sequence_engine
//
// Purpose:
//   Memory-game sequencer. Each round R it shows the first R+1 words of an
//   external sequence ROM on the LEDs, then checks R+1 one-hot key presses
//   against the same words. The game ends in WIN, LOSE (wrong key) or TOUT
//   (no key within the allowed time).
//
// Build option:
//   GENIUS_TIMEOUT_EN - when defined, a per-play timer sends the game to TOUT
//                       after TIMEOUT_CYCLES idle cycles in WAIT_PLAY. When
//                       undefined there is no timer, WAIT_PLAY waits forever
//                       and `timeout` stays 0.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous reset, active low
//   iniciar    in   start/restart request (level, sampled each clock)
//   sel_nivel  in   1 = hard (MAX_ROUNDS rounds), 0 = easy (MAX_ROUNDS/2)
//   keys       in   player keys, synchronised, one-hot expected
//   mem_data   in   ROM word at mem_addr (combinational)
//   mem_addr   out  ROM address (registered)
//   leds       out  player LEDs
//   pronto     out  game over
//   acertou    out  game won
//   errou      out  game lost (wrong key or timeout)
//   timeout    out  loss caused by timeout
//   db_rodada  out  current round index R
//   db_estado  out  state code
// ---------------------------------------------------------------------------
module genius_sequence_engine #(
    parameter int N_KEYS         = 4,
    parameter int MAX_ROUNDS     = 16,
    parameter int SHOW_CYCLES    = 500,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic                          sel_nivel,
    input  logic [N_KEYS-1:0]             keys,
    input  logic [N_KEYS-1:0]             mem_data,
    output logic [$clog2(MAX_ROUNDS)-1:0] mem_addr,
    output logic [N_KEYS-1:0]             leds,
    output logic                          pronto,
    output logic                          acertou,
    output logic                          errou,
    output logic                          timeout,
    output logic [$clog2(MAX_ROUNDS)-1:0] db_rodada,
    output logic [3:0]                    db_estado
);

    localparam int AW        = $clog2(MAX_ROUNDS);
    localparam int PHASE_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [PW-1:0] SHOW_END  = PW'(SHOW_CYCLES - 1);
    localparam logic [PW-1:0] GAP_END   = PW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] LAST_HARD = AW'(MAX_ROUNDS - 1);
    localparam logic [AW-1:0] LAST_EASY = AW'(MAX_ROUNDS / 2 - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_PREP       = 4'd1,
        S_SHOW_ON    = 4'd2,
        S_SHOW_OFF   = 4'd3,
        S_WAIT_PLAY  = 4'd4,
        S_COMPARE    = 4'd5,
        S_NEXT_ROUND = 4'd6,
        S_WIN        = 4'd7,
        S_LOSE       = 4'd8,
        S_TOUT       = 4'd9
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_round;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_last;
    logic [PW-1:0]       r_phase;
    logic                r_any_q;
    logic [N_KEYS-1:0]   r_play_q;

    logic                w_any;
    logic                w_play;
    logic                w_phase_done;
    logic                w_match;
    logic                w_tout;

    // A play is the rising edge of "any key down"; holding a key cannot
    // produce a second event because r_any_q stays high.
    assign w_any   = |keys;
    assign w_play  = w_any & ~r_any_q;
    assign w_match = (r_play_q == mem_data);

    assign w_phase_done = ((r_state == S_SHOW_ON)  && (r_phase == SHOW_END)) ||
                          ((r_state == S_SHOW_OFF) && (r_phase == GAP_END));

`ifdef GENIUS_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TOUT_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo;

    // Held at zero outside WAIT_PLAY, so every entry into WAIT_PLAY
    // (after a show or after an accepted play) starts a fresh window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (r_state != S_WAIT_PLAY) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tout = (r_state == S_WAIT_PLAY) && (r_tmo == TOUT_END);
`else
    // Always 0; the comparison only keeps TIMEOUT_CYCLES referenced here.
    assign w_tout = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (iniciar) w_next = S_PREP;
            end
            S_PREP: begin
                w_next = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (w_phase_done) w_next = S_SHOW_OFF;
            end
            S_SHOW_OFF: begin
                if (w_phase_done) begin
                    w_next = (r_addr == r_round) ? S_WAIT_PLAY : S_SHOW_ON;
                end
            end
            S_WAIT_PLAY: begin
                // A play on the last timer cycle still counts.
                if (w_play) begin
                    w_next = S_COMPARE;
                end else if (w_tout) begin
                    w_next = S_TOUT;
                end
            end
            S_COMPARE: begin
                // Multi-hot presses can never equal a one-hot ROM word.
                if (!w_match) begin
                    w_next = S_LOSE;
                end else if (r_addr < r_round) begin
                    w_next = S_WAIT_PLAY;
                end else if (r_round == r_last) begin
                    w_next = S_WIN;
                end else begin
                    w_next = S_NEXT_ROUND;
                end
            end
            S_NEXT_ROUND: begin
                w_next = S_SHOW_ON;
            end
            S_WIN, S_LOSE, S_TOUT: begin
                if (iniciar) w_next = S_PREP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Round, address and difficulty registers. The LAST check in COMPARE
    // happens before any increment, so neither R nor mem_addr wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_round <= '0;
            r_addr  <= '0;
            r_last  <= '0;
        end else begin
            case (r_state)
                S_PREP: begin
                    r_round <= '0;
                    r_addr  <= '0;
                    r_last  <= sel_nivel ? LAST_HARD : LAST_EASY;
                end
                S_SHOW_OFF: begin
                    if (w_phase_done) begin
                        r_addr <= (r_addr == r_round) ? '0 : r_addr + 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (w_match && (r_addr < r_round)) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_NEXT_ROUND: begin
                    r_round <= r_round + 1'b1;
                    r_addr  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Show/gap duration counter, shared by SHOW_ON and SHOW_OFF.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else if ((r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF)) begin
            r_phase <= w_phase_done ? '0 : r_phase + 1'b1;
        end else begin
            r_phase <= '0;
        end
    end

    // Key edge tracking runs in every state so keys held from outside
    // WAIT_PLAY cannot fire once WAIT_PLAY is entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_any_q  <= 1'b0;
            r_play_q <= '0;
        end else begin
            r_any_q <= w_any;
            if (w_play) r_play_q <= keys;
        end
    end

    // Moore outputs
    always_comb begin
        leds    = '0;
        pronto  = 1'b0;
        acertou = 1'b0;
        errou   = 1'b0;
        timeout = 1'b0;
        case (r_state)
            S_SHOW_ON:   leds = mem_data;
            S_WAIT_PLAY: leds = keys;
            S_WIN: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            S_LOSE: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            S_TOUT: begin
                pronto  = 1'b1;
                errou   = 1'b1;
`ifdef GENIUS_TIMEOUT_EN
                timeout = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    assign mem_addr  = r_addr;
    assign db_rodada = r_round;
    assign db_estado = r_state;

endmodule

// File: tb/tb_genius_sequence_engine.sv
// ---------------------------------------------------------------------------
// tb_genius_sequence_engine
//
// Purpose:
//   Scoreboard bench for genius_sequence_engine with N_KEYS=4, MAX_ROUNDS=4,
//   SHOW_CYCLES=2, GAP_CYCLES=1, TIMEOUT_CYCLES=20 and ROM 0001/0010/0100/1000.
//   Stimulus pushes the expected shown words and game outcomes into queues;
//   a monitor pops them when the DUT leaves SHOW_ON or raises pronto.
//   Expectations follow GENIUS_TIMEOUT_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_genius_sequence_engine;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       iniciar   = 1'b0;
    logic       sel_nivel = 1'b0;
    logic [3:0] keys      = 4'b0000;
    logic [3:0] mem_data;
    logic [1:0] mem_addr;
    logic [3:0] leds;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [1:0] db_rodada;
    logic [3:0] db_estado;

    logic [3:0] rom [0:3];

    genius_sequence_engine #(
        .N_KEYS        (4),
        .MAX_ROUNDS    (4),
        .SHOW_CYCLES   (2),
        .GAP_CYCLES    (1),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .sel_nivel(sel_nivel),
        .keys     (keys),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .leds     (leds),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .timeout  (timeout),
        .db_rodada(db_rodada),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b0010;
        rom[2] = 4'b0100;
        rom[3] = 4'b1000;
    end

    assign mem_data = rom[mem_addr];

    typedef struct {
        logic [3:0] word;
        logic [1:0] addr;
        int         len;
    } show_t;

    // vec = {pronto, acertou, errou, timeout, db_rodada, db_estado}
    typedef struct {
        logic [9:0] vec;
        int         lat;
        int         wrun;
    } out_t;

    show_t show_q[$];
    out_t  out_q[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int press_cyc = 0;
    int max_addr  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        logic [3:0] prev_est    = 4'd0;
        logic       prev_pronto = 1'b0;
        logic [3:0] s_word      = 4'd0;
        logic [1:0] s_addr      = 2'd0;
        int         s_len       = 0;
        int         wrun        = 0;
        int         last_wrun   = 0;
        show_t      es;
        out_t       eo;
        forever begin
            @(negedge clock);
            if (db_estado >= 4'd2 && db_estado <= 4'd6 && 32'(mem_addr) > max_addr)
                max_addr = 32'(mem_addr);

            if (db_estado == 4'd2) begin
                if (prev_est != 4'd2) begin
                    s_word = leds;
                    s_addr = mem_addr;
                    s_len  = 0;
                end
                s_len++;
            end else if (prev_est == 4'd2 && db_estado == 4'd3) begin
                if (show_q.size() == 0) begin
                    check("show_unexpected", 32'({s_word, s_addr}), 32'hFFFF);
                end else begin
                    es = show_q.pop_front();
                    check("show_word_addr_len", 32'({s_word, s_addr, 8'(s_len)}),
                          32'({es.word, es.addr, 8'(es.len)}));
                end
            end

            if (db_estado == 4'd4) begin
                wrun++;
            end else begin
                if (prev_est == 4'd4) last_wrun = wrun;
                wrun = 0;
            end

            if (pronto && !prev_pronto) begin
                if (out_q.size() == 0) begin
                    check("outcome_unexpected", 32'(db_estado), 32'hFFFF);
                end else begin
                    eo = out_q.pop_front();
                    check("outcome", 32'({pronto, acertou, errou, timeout, db_rodada, db_estado}),
                          32'(eo.vec));
                    if (eo.lat >= 0) check("outcome_latency", 32'(cyc - press_cyc), 32'(eo.lat));
                    if (eo.wrun >= 0) check("wait_play_cycles", 32'(last_wrun), 32'(eo.wrun));
                end
            end
            prev_est    = db_estado;
            prev_pronto = pronto;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int n = 0;
        while (db_estado !== s && n < budget) begin
            tick();
            n++;
        end
        check(nm, 32'(db_estado), 32'(s));
    endtask

    task automatic wait_pronto(input int budget, input string nm);
        int n = 0;
        while (pronto !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(nm, 32'(pronto), 32'd1);
    endtask

    task automatic press(input logic [3:0] w);
        keys      = w;
        press_cyc = cyc;
        repeat (5) tick();
        keys = 4'b0000;
        repeat (5) tick();
    endtask

    task automatic start(input bit hard, input bit chk_prep);
        sel_nivel = hard;
        iniciar   = 1'b1;
        tick();
        iniciar   = 1'b0;
        if (chk_prep) begin
            check("prep_state", 32'(db_estado), 32'd1);
            check("prep_flags_clear", 32'({pronto, acertou, errou, timeout}), 32'd0);
        end
    endtask

    task automatic push_shows(input int last_r);
        show_t s;
        for (int r = 0; r <= last_r; r++) begin
            for (int i = 0; i <= r; i++) begin
                s.word = rom[i];
                s.addr = 2'(i);
                s.len  = 2;
                show_q.push_back(s);
            end
        end
    endtask

    task automatic push_out(input logic [9:0] vec, input int lat, input int wrun);
        out_t o;
        o.vec  = vec;
        o.lat  = lat;
        o.wrun = wrun;
        out_q.push_back(o);
    endtask

    // bad_r < 0 means every play is correct.
    task automatic run_game(input bit hard, input int last_r, input int bad_r, input int bad_i,
                            input logic [3:0] bad_w, input bit chk_prep, input string nm);
        int top;
        bit done;
        top  = (bad_r >= 0) ? bad_r : last_r;
        done = 1'b0;
        push_shows(top);
        if (bad_r >= 0) push_out({4'b1010, 2'(bad_r), 4'd8}, 2, -1);
        else            push_out({4'b1100, 2'(last_r), 4'd7}, 2, -1);
        start(hard, chk_prep);
        for (int r = 0; r <= top && !done; r++) begin
            for (int i = 0; i <= r && !done; i++) begin
                wait_state(4'd4, 100, {nm, "_reach_wait"});
                if (r == bad_r && i == bad_i) begin
                    press(bad_w);
                    done = 1'b1;
                end else begin
                    press(rom[i]);
                end
            end
        end
        wait_pronto(60, {nm, "_done"});
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              32'({mem_addr, leds, pronto, acertou, errou, timeout, db_rodada, db_estado}), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_after_reset", 32'(db_estado), 32'd0);

        // Hard mode, all correct
        run_game(1'b1, 3, -1, 0, 4'b0000, 1'b0, "hard_win");

        // Restart from WIN with iniciar, replay and win again
        run_game(1'b1, 3, -1, 0, 4'b0000, 1'b1, "replay_win");

        // Easy mode
        max_addr = 0;
        run_game(1'b0, 1, -1, 0, 4'b0000, 1'b0, "easy_win");
        check("easy_max_addr", 32'(max_addr), 32'd1);

        // Round 2, second play wrong
        run_game(1'b1, 3, 2, 1, 4'b0100, 1'b0, "lose_r2");
        check("lose_state", 32'(db_estado), 32'd8);

        // Key held across the show-to-play boundary, then a multi-hot press
        push_shows(0);
`ifdef GENIUS_TIMEOUT_EN
        push_out({4'b1011, 2'd0, 4'd9}, -1, 20);
`endif
        start(1'b1, 1'b0);
        wait_state(4'd2, 20, "held_reach_show");
        keys = 4'b0010;
        repeat (30) tick();
`ifndef GENIUS_TIMEOUT_EN
        check("held_no_event", 32'(db_estado), 32'd4);
        check("held_echo_leds", 32'(leds), 32'h2);
`endif
        keys = 4'b0000;
        repeat (3) tick();
`ifdef GENIUS_TIMEOUT_EN
        check("held_tout", 32'(db_estado), 32'd9);
        push_shows(0);
        push_out({4'b1010, 2'd0, 4'd8}, 2, -1);
        start(1'b1, 1'b0);
        wait_state(4'd4, 40, "multihot_reach_wait");
`else
        push_out({4'b1010, 2'd0, 4'd8}, 2, -1);
`endif
        press(4'b0011);
        wait_pronto(60, "multihot_done");

        // No key at all in WAIT_PLAY
        push_shows(0);
`ifdef GENIUS_TIMEOUT_EN
        push_out({4'b1011, 2'd0, 4'd9}, -1, 20);
        start(1'b1, 1'b0);
        wait_pronto(60, "tout_done");
        check("tout_flag", 32'(timeout), 32'd1);
`else
        start(1'b1, 1'b0);
        wait_state(4'd4, 20, "notout_reach_wait");
        repeat (40) tick();
        check("notout_state", 32'(db_estado), 32'd4);
        check("notout_flags", 32'({timeout, pronto}), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
`endif

        // Asynchronous reset in the middle of SHOW_ON
        start(1'b1, 1'b0);
        wait_state(4'd2, 20, "rst_reach_show");
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({mem_addr, leds, pronto, acertou, errou, timeout, db_rodada, db_estado}), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("idle_after_async_reset", 32'(db_estado), 32'd0);

        check("sb_show_empty", 32'(show_q.size()), 32'd0);
        check("sb_outcome_empty", 32'(out_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
